// File: rtl/imap_rd_sched_pkg.sv
// Shared accelerator constants, scan FSM state type and address geometry
// for the input-map read scheduler.
package imap_rd_sched_pkg;

   localparam int unsigned MAP_DIM    = 56;
   localparam int unsigned BLOCK_SIZE = MAP_DIM * MAP_DIM;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 64;
   localparam int unsigned DIM_W      = 6;
   // Offset field wide enough for one channel block (3136 -> 12 bits)
   localparam int unsigned OFF_W      = $clog2(BLOCK_SIZE);
   localparam int unsigned PAD_W      = ADDR_W - OFF_W - 1;

   localparam logic [DIM_W-1:0] DIM_MAX  = DIM_W'(MAP_DIM);
   localparam logic [OFF_W-1:0] ROW_STEP = OFF_W'(MAP_DIM);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   function automatic logic dim_legal(input logic [DIM_W-1:0] d);
      return (d != '0) && (d <= DIM_MAX);
   endfunction

endpackage

// File: rtl/imap_rw_arb.sv
// Two-requester round-robin arbiter for the single-port input-map SRAM.
// Priority only flips on contention; the first contention after reset goes to write.
module imap_rw_arb (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req_wr,
   input  logic i_req_rd,
   output logic o_gnt_wr,
   output logic o_gnt_rd
);

   logic r_last_wr;
   logic w_contend;

   assign w_contend = i_req_wr & i_req_rd;
   assign o_gnt_wr  = i_req_wr & (~i_req_rd | ~r_last_wr);
   assign o_gnt_rd  = i_req_rd & ~o_gnt_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last_wr <= 1'b0;
      else if (w_contend)
         r_last_wr <= o_gnt_wr;
   end

endmodule

// File: rtl/imap_rd_sched.sv
// Input-map read scheduler: scans blk/y/x over the buffer, feeding the MAC,
// while sharing the single SRAM port with BIU writes through imap_rw_arb.
module imap_rd_sched
   import imap_rd_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIM_W-1:0]  cfg_h,
   input  logic [DIM_W-1:0]  cfg_w,
   input  logic              cfg_two_blk,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              mac_ready,
   output logic              dout_valid,
   output logic [ADDR_W-1:0] imap_waddr,
   output logic [DATA_W-1:0] imap_wdata,
   output logic              imap_wen,
   output logic [ADDR_W-1:0] imap_raddr,
   output logic              imap_ren,
   output logic              busy,
   output logic              done
);

   state_t            r_state, w_state_nxt;
   logic [DIM_W-1:0]  r_h, r_w, r_y, r_x;
   logic              r_two, r_blk;
   logic [OFF_W-1:0]  r_row_base;
   logic              r_ren_d, r_err_done;

   logic              w_req_wr, w_req_rd, w_gnt_wr, w_gnt_rd;
   logic              w_cfg_ok, w_launch;
   logic              w_x_last, w_y_last, w_blk_last, w_scan_last;
   logic [OFF_W-1:0]  w_off;

   assign w_cfg_ok    = dim_legal(cfg_h) & dim_legal(cfg_w);
   assign w_launch    = (r_state == ST_IDLE) & start & w_cfg_ok;
   assign w_x_last    = (r_x == r_w - 1'b1);
   assign w_y_last    = (r_y == r_h - 1'b1);
   assign w_blk_last  = r_blk | ~r_two;
   assign w_scan_last = w_x_last & w_y_last & w_blk_last;

   // Write requests are combinational from wr_valid, so gate them during reset
   assign w_req_wr = wr_valid & rst_n;
   assign w_req_rd = (r_state == ST_RUN) & mac_ready;

   imap_rw_arb u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req_wr (w_req_wr),
      .i_req_rd (w_req_rd),
      .o_gnt_wr (w_gnt_wr),
      .o_gnt_rd (w_gnt_rd)
   );

   assign w_off      = r_row_base + {{(OFF_W-DIM_W){1'b0}}, r_x};
   assign imap_raddr = {{PAD_W{1'b0}}, r_blk, w_off};
   assign imap_ren   = w_gnt_rd;
   assign imap_wen   = w_gnt_wr;
   assign wr_ready   = w_gnt_wr;
   assign imap_waddr = w_gnt_wr ? wr_addr : '0;
   assign imap_wdata = w_gnt_wr ? wr_data : '0;
   assign dout_valid = r_ren_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = r_err_done;
      case (r_state)
         ST_IDLE:  if (w_launch) w_state_nxt = ST_RUN;
         ST_RUN: begin
            busy = 1'b1;
            if (w_gnt_rd && w_scan_last) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h        <= '0;
         r_w        <= '0;
         r_two      <= 1'b0;
         r_blk      <= 1'b0;
         r_y        <= '0;
         r_x        <= '0;
         r_row_base <= '0;
         r_ren_d    <= 1'b0;
         r_err_done <= 1'b0;
      end else begin
         r_ren_d    <= w_gnt_rd;
         r_err_done <= (r_state == ST_IDLE) & start & ~w_cfg_ok;
         if (w_launch) begin
            r_h        <= cfg_h;
            r_w        <= cfg_w;
            r_two      <= cfg_two_blk;
            r_blk      <= 1'b0;
            r_y        <= '0;
            r_x        <= '0;
            r_row_base <= '0;
         end else if (w_gnt_rd) begin
            if (!w_x_last) begin
               r_x <= r_x + 1'b1;
            end else begin
               r_x <= '0;
               if (!w_y_last) begin
                  r_y        <= r_y + 1'b1;
                  r_row_base <= r_row_base + ROW_STEP;
               end else begin
                  r_y        <= '0;
                  r_row_base <= '0;
                  if (!w_blk_last) r_blk <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_imap_rd_sched.sv
// Self-checking bench for imap_rd_sched: queue-based scan/arbitration model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_imap_rd_sched;

   logic        clk, rst_n, start, cfg_two_blk;
   logic [5:0]  cfg_h, cfg_w;
   logic        wr_valid, wr_ready, mac_ready, dout_valid;
   logic [31:0] wr_addr, imap_waddr, imap_raddr;
   logic [63:0] wr_data, imap_wdata;
   logic        imap_wen, imap_ren, busy, done;

   imap_rd_sched dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_h(cfg_h), .cfg_w(cfg_w),
      .cfg_two_blk(cfg_two_blk), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ready(wr_ready), .mac_ready(mac_ready),
      .dout_valid(dout_valid), .imap_waddr(imap_waddr), .imap_wdata(imap_wdata),
      .imap_wen(imap_wen), .imap_raddr(imap_raddr), .imap_ren(imap_ren),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: pending read addresses of the active scan, in scan order
   int unsigned m_q[$];
   bit m_active, m_err, m_last_wr, m_prev_ren;
   bit rreq, drain, egw, egr, was_act;

   // Capture of observed behaviour for the directed literal checks
   logic [31:0] cap_q[$];
   logic [1:0]  pat_q[$];
   int cyc = 0, ren_cnt, dv_cnt, done_cnt, consec, first_ren_cyc, done_cyc;
   bit act_prev_ren;

   task automatic clear_cap();
      cap_q.delete(); pat_q.delete();
      ren_cnt = 0; dv_cnt = 0; done_cnt = 0; consec = 0;
      first_ren_cyc = 0; done_cyc = 0;
   endtask

   task automatic build_scan(input int h, input int w, input bit two);
      m_q.delete();
      for (int b = 0; b < (two ? 2 : 1); b++)
         for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
               m_q.push_back(b * 4096 + y * 56 + x);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_dout_valid", dout_valid, 0);
         chk("rst_wr_ready", wr_ready, 0);
         chk("rst_wen", imap_wen, 0);
         chk("rst_ren", imap_ren, 0);
         chk("rst_raddr", imap_raddr, 0);
         chk("rst_waddr", imap_waddr, 0);
         chk("rst_wdata", imap_wdata, 0);
         m_q.delete();
         m_active = 0; m_err = 0; m_last_wr = 0; m_prev_ren = 0;
         act_prev_ren = 0;
      end else begin
         rreq  = m_active && (m_q.size() != 0) && mac_ready;
         drain = m_active && (m_q.size() == 0);
         egw   = wr_valid && (!rreq || !m_last_wr);
         egr   = rreq && !egw;
         chk("wen", imap_wen, egw);
         chk("wr_ready", wr_ready, egw);
         chk("ren", imap_ren, egr);
         chk("wen_ren_excl", imap_wen & imap_ren, 0);
         chk("dout_valid", dout_valid, m_prev_ren);
         chk("done", done, drain || m_err);
         chk("busy", busy, m_active);
         if (egw) begin
            chk("waddr", imap_waddr, wr_addr);
            chk("wdata", imap_wdata, wr_data);
         end
         if (egr) chk("raddr", imap_raddr, m_q[0]);

         if (imap_ren) begin
            if (ren_cnt == 0) first_ren_cyc = cyc;
            ren_cnt++;
            cap_q.push_back(imap_raddr);
            if (act_prev_ren) consec++;
         end
         act_prev_ren = imap_ren;
         if (dout_valid) dv_cnt++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (busy) pat_q.push_back({imap_wen, imap_ren});

         was_act = m_active;
         if (wr_valid && rreq) m_last_wr = egw;
         m_prev_ren = egr;
         if (egr) void'(m_q.pop_front());
         if (drain) m_active = 0;
         m_err = 0;
         if (!was_act && start) begin
            if (cfg_h >= 1 && cfg_h <= 56 && cfg_w >= 1 && cfg_w <= 56) begin
               build_scan(int'(cfg_h), int'(cfg_w), cfg_two_blk);
               m_active = 1;
            end else begin
               m_err = 1;
            end
         end
      end
   end

   task automatic pulse_start(input logic [5:0] h, input logic [5:0] w, input logic two);
      @(posedge clk); #1;
      cfg_h = h; cfg_w = w; cfg_two_blk = two; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string nm);
      bit seen;
      seen = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #1;
         if (done_cnt > 0) begin seen = 1; break; end
      end
      chk(nm, seen, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   int unsigned exp6[6] = '{0, 1, 2, 56, 57, 58};
   int unsigned exp4[4] = '{32'h0000, 32'h0001, 32'h1000, 32'h1001};
   int bad;
   bit seen;

   initial begin
      rst_n = 0; start = 0; cfg_h = 0; cfg_w = 0; cfg_two_blk = 0;
      wr_valid = 0; wr_addr = 32'hA5A5_0010; wr_data = 64'h1234_5678_9ABC_DEF0;
      mac_ready = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (2) @(posedge clk);
      #1;

      // H=2 W=3 single block, MAC always ready
      clear_cap();
      pulse_start(6'd2, 6'd3, 1'b0);
      wait_done(40, "t034_done_timeout");
      chk("t034_nreads", cap_q.size(), 6);
      if (cap_q.size() == 6)
         for (int i = 0; i < 6; i++) chk("t034_addr", cap_q[i], exp6[i]);
      chk("t034_done_latency", done_cyc - first_ren_cyc, 6);
      chk("t034_dv_cnt", dv_cnt, 6);
      chk("t034_done_cnt", done_cnt, 1);

      // H=1 W=2 two blocks
      clear_cap();
      pulse_start(6'd1, 6'd2, 1'b1);
      wait_done(40, "t035_done_timeout");
      chk("t035_nreads", cap_q.size(), 4);
      if (cap_q.size() == 4)
         for (int i = 0; i < 4; i++) chk("t035_addr", cap_q[i], exp4[i]);
      chk("t035_dv_cnt", dv_cnt, 4);
      chk("t035_done_cnt", done_cnt, 1);

      // Writes held high through a scan: strict alternation, write first
      clear_cap();
      wr_valid = 1;
      pulse_start(6'd2, 6'd3, 1'b0);
      wait_done(60, "t036_done_timeout");
      wr_valid = 0;
      chk("t036_busy_cycles", pat_q.size(), 13);
      if (pat_q.size() >= 12) begin
         chk("t036_first_contention", pat_q[0], 2'b10);
         bad = 0;
         for (int i = 0; i < 12; i++)
            if (pat_q[i] != ((i % 2 == 0) ? 2'b10 : 2'b01)) bad++;
         chk("t036_alternation", bad, 0);
      end
      if (cap_q.size() == 6)
         for (int i = 0; i < 6; i++) chk("t036_addr", cap_q[i], exp6[i]);

      // Illegal widths: immediate done, no reads, never busy
      clear_cap();
      pulse_start(6'd2, 6'd0, 1'b0);
      chk("t037_w0_done", done, 1);
      chk("t037_w0_busy", busy, 0);
      @(posedge clk); #1;
      chk("t037_w0_done_clear", done, 0);
      pulse_start(6'd2, 6'd57, 1'b0);
      chk("t037_w57_done", done, 1);
      chk("t037_w57_busy", busy, 0);
      repeat (3) @(posedge clk); #1;
      chk("t037_no_ren", ren_cnt, 0);
      chk("t037_done_cnt", done_cnt, 2);

      // mac_ready toggling, plus a start pulse mid-scan that must be ignored
      clear_cap();
      pulse_start(6'd2, 6'd3, 1'b0);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         mac_ready = ~mac_ready;
         start = (i == 3);
         cfg_w = (i == 3) ? 6'd1 : 6'd3;
         if (done_cnt > 0) begin seen = 1; break; end
      end
      start = 0; mac_ready = 1;
      chk("t038_done_timeout", seen, 1);
      repeat (2) @(posedge clk); #1;
      chk("t038_nreads", cap_q.size(), 6);
      if (cap_q.size() == 6)
         for (int i = 0; i < 6; i++) chk("t038_addr", cap_q[i], exp6[i]);
      chk("t038_no_back_to_back", consec, 0);
      chk("t038_done_cnt", done_cnt, 1);

      // Reset mid-scan after 3 reads, then a fresh scan
      clear_cap();
      pulse_start(6'd2, 6'd3, 1'b0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (ren_cnt >= 3) begin seen = 1; break; end
      end
      chk("t039_three_reads", seen, 1);
      rst_n = 0; wr_valid = 1;
      #1;
      chk("t039_busy", busy, 0);
      chk("t039_done", done, 0);
      chk("t039_ren", imap_ren, 0);
      chk("t039_wen", imap_wen, 0);
      chk("t039_wr_ready", wr_ready, 0);
      chk("t039_dout_valid", dout_valid, 0);
      chk("t039_raddr", imap_raddr, 0);
      chk("t039_waddr", imap_waddr, 0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1; wr_valid = 0;
      repeat (2) @(posedge clk); #1;
      chk("t039_no_done", done_cnt, 0);
      clear_cap();
      pulse_start(6'd2, 6'd3, 1'b0);
      wait_done(40, "t039_done_timeout");
      chk("t039_nreads", cap_q.size(), 6);
      if (cap_q.size() == 6)
         for (int i = 0; i < 6; i++) chk("t039_addr", cap_q[i], exp6[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
